// File: rtl/psum_buf_sched_pkg.sv
// Shared definitions for the partial-sum buffer port scheduler.
package psum_buf_sched_pkg;

   localparam int STATE_W = 3;

   typedef enum logic [STATE_W-1:0] {
      S_IDLE  = 3'd0,
      S_CLEAR = 3'd1,
      S_ACCUM = 3'd2,
      S_DRAIN = 3'd3,
      S_DONE  = 3'd4
   } state_t;

endpackage

// File: rtl/psum_sched_fifo.sv
// Small synchronous skid FIFO that holds drained words until the output stream accepts them.
module psum_sched_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic                       pop,
   input  logic [WIDTH-1:0]           din,
   output logic [WIDTH-1:0]           dout,
   output logic                       empty,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;

   function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
      if (p == PW'(DEPTH-1)) begin
         return '0;
      end else begin
         return p + PW'(1);
      end
   endfunction

   // Storage, pointers and occupancy; the caller never pushes when full or pops when empty.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= ptr_next(wr_ptr);
         end
         if (pop) begin
            rd_ptr <= ptr_next(rd_ptr);
         end
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   assign dout  = mem[rd_ptr];
   assign empty = (count == '0);

endmodule

// File: rtl/psum_buf_sched.sv
// Owns the single psum buffer port for one layer pass: zero-clear, accumulator passthrough, then drain to a stream.
module psum_buf_sched
   import psum_buf_sched_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int REG_WIDTH  = 32,
   parameter int MEM_DELAY  = 2,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_start,
   input  logic [REG_WIDTH-1:0]  i_conf_numwords,
   input  logic                  i_accum_done,
   input  logic [ADDR_WIDTH-1:0] acc_wadd,
   input  logic                  acc_wren,
   input  logic [DATA_WIDTH-1:0] acc_idat,
   input  logic [ADDR_WIDTH-1:0] acc_radd,
   input  logic                  acc_rden,
   output logic [DATA_WIDTH-1:0] acc_odat,
   output logic                  acc_ovld,
   output logic [ADDR_WIDTH-1:0] mem_wadd,
   output logic                  mem_wren,
   output logic [DATA_WIDTH-1:0] mem_idat,
   output logic [ADDR_WIDTH-1:0] mem_radd,
   output logic                  mem_rden,
   input  logic [DATA_WIDTH-1:0] mem_odat,
   input  logic                  mem_ovld,
   output logic [DATA_WIDTH-1:0] o_dat,
   output logic                  o_vld,
   output logic                  o_last,
   input  logic                  i_rdy,
   output logic                  o_busy,
   output logic                  o_done,
   output logic                  o_err_conflict,
   output logic [STATE_W-1:0]    o_state
);

   localparam int CW = $clog2(FIFO_DEPTH+1);

   state_t                state;
   logic [REG_WIDTH-1:0]  n_words;
   logic [REG_WIDTH-1:0]  clr_cnt;
   logic [REG_WIDTH-1:0]  rd_cnt;
   logic [REG_WIDTH-1:0]  pop_cnt;
   logic [CW-1:0]         inflight;
   logic [CW-1:0]         fifo_count;
   logic [CW:0]           credit_used;
   logic [DATA_WIDTH-1:0] fifo_dout;
   logic                  fifo_empty;
   logic                  fifo_push;
   logic                  fifo_pop;
   logic                  drain_rden;
   logic                  n_zero;
   logic                  last_clear;
   logic                  last_pop;
   logic                  err;

   assign n_zero      = (n_words == '0);
   assign last_clear  = (clr_cnt == n_words - REG_WIDTH'(1));
   assign last_pop    = (pop_cnt == n_words - REG_WIDTH'(1));
   // Reads in flight plus words parked in the FIFO can never exceed its depth, so pushes never overflow.
   assign credit_used = {1'b0, inflight} + {1'b0, fifo_count};
   assign drain_rden  = (state == S_DRAIN) && (rd_cnt < n_words) &&
                        (credit_used < (CW+1)'(FIFO_DEPTH));
   assign fifo_push   = (state == S_DRAIN) && mem_ovld;
   assign o_vld       = (state == S_DRAIN) && !fifo_empty;
   assign fifo_pop    = o_vld && i_rdy;

   psum_sched_fifo #(
      .WIDTH (DATA_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .din   (mem_odat),
      .dout  (fifo_dout),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   // Memory port mux: the scheduler drives it except during ACCUM, where the accumulator owns it.
   always_comb begin
      mem_wadd = '0;
      mem_wren = 1'b0;
      mem_idat = '0;
      mem_radd = '0;
      mem_rden = 1'b0;
      acc_odat = '0;
      acc_ovld = 1'b0;
      case (state)
         S_CLEAR: begin
            if (!n_zero) begin
               mem_wren = 1'b1;
               mem_wadd = ADDR_WIDTH'(clr_cnt);
            end else begin
               mem_wren = 1'b0;
            end
         end
         S_ACCUM: begin
            mem_wadd = acc_wadd;
            mem_wren = acc_wren;
            mem_idat = acc_idat;
            mem_radd = acc_radd;
            mem_rden = acc_rden;
            acc_odat = mem_odat;
            acc_ovld = mem_ovld;
         end
         S_DRAIN: begin
            mem_rden = drain_rden;
            mem_radd = ADDR_WIDTH'(rd_cnt);
         end
         default: begin
            mem_rden = 1'b0;
         end
      endcase
   end

   // Phase sequencing, drain counters and the sticky port-conflict flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         n_words  <= '0;
         clr_cnt  <= '0;
         rd_cnt   <= '0;
         pop_cnt  <= '0;
         inflight <= '0;
         err      <= 1'b0;
      end else begin
         if ((state != S_ACCUM) && (acc_wren || acc_rden)) begin
            err <= 1'b1;
         end
         case ({drain_rden, fifo_push})
            2'b10:   inflight <= inflight + CW'(1);
            2'b01:   inflight <= inflight - CW'(1);
            default: inflight <= inflight;
         endcase
         if (drain_rden) begin
            rd_cnt <= rd_cnt + REG_WIDTH'(1);
         end
         if (fifo_pop) begin
            pop_cnt <= pop_cnt + REG_WIDTH'(1);
         end
         case (state)
            S_IDLE: begin
               if (i_start) begin
                  n_words  <= i_conf_numwords;
                  clr_cnt  <= '0;
                  rd_cnt   <= '0;
                  pop_cnt  <= '0;
                  inflight <= '0;
                  state    <= S_CLEAR;
               end
            end
            S_CLEAR: begin
               if (n_zero || last_clear) begin
                  state <= S_ACCUM;
               end else begin
                  clr_cnt <= clr_cnt + REG_WIDTH'(1);
               end
            end
            S_ACCUM: begin
               if (i_accum_done) begin
                  state <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (n_zero || (fifo_pop && last_pop)) begin
                  state <= S_DONE;
               end
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   assign o_dat          = o_vld ? fifo_dout : '0;
   assign o_last         = o_vld && last_pop;
   assign o_busy         = (state != S_IDLE);
   assign o_done         = (state == S_DONE);
   assign o_err_conflict = err;
   assign o_state        = state;

endmodule

// File: tb/tb_psum_buf_sched.sv
// Directed bench for psum_buf_sched with a two-cycle-latency buffer memory model.
module tb_psum_buf_sched;

   localparam int DW = 32;
   localparam int AW = 32;
   localparam int RW = 32;
   localparam int FD = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          i_start = 1'b0;
   logic [RW-1:0] i_conf_numwords = '0;
   logic          i_accum_done = 1'b0;
   logic [AW-1:0] acc_wadd = '0;
   logic          acc_wren = 1'b0;
   logic [DW-1:0] acc_idat = '0;
   logic [AW-1:0] acc_radd = '0;
   logic          acc_rden = 1'b0;
   logic [DW-1:0] acc_odat;
   logic          acc_ovld;
   logic [AW-1:0] mem_wadd;
   logic          mem_wren;
   logic [DW-1:0] mem_idat;
   logic [AW-1:0] mem_radd;
   logic          mem_rden;
   logic [DW-1:0] mem_odat;
   logic          mem_ovld;
   logic [DW-1:0] o_dat;
   logic          o_vld;
   logic          o_last;
   logic          i_rdy = 1'b0;
   logic          o_busy;
   logic          o_done;
   logic          o_err_conflict;
   logic [2:0]    o_state;

   logic          force_ovld = 1'b0;
   logic [DW-1:0] force_dat = '0;

   int n_tests = 0;
   int n_fail  = 0;
   logic [DW-1:0] exp_w [16];

   always #5 clk = ~clk;

   psum_buf_sched dut (
      .clk(clk), .rst(rst), .i_start(i_start), .i_conf_numwords(i_conf_numwords),
      .i_accum_done(i_accum_done), .acc_wadd(acc_wadd), .acc_wren(acc_wren),
      .acc_idat(acc_idat), .acc_radd(acc_radd), .acc_rden(acc_rden),
      .acc_odat(acc_odat), .acc_ovld(acc_ovld), .mem_wadd(mem_wadd),
      .mem_wren(mem_wren), .mem_idat(mem_idat), .mem_radd(mem_radd),
      .mem_rden(mem_rden), .mem_odat(mem_odat), .mem_ovld(mem_ovld),
      .o_dat(o_dat), .o_vld(o_vld), .o_last(o_last), .i_rdy(i_rdy),
      .o_busy(o_busy), .o_done(o_done), .o_err_conflict(o_err_conflict),
      .o_state(o_state)
   );

   // Buffer memory model: read data returns two cycles after rden.
   logic [DW-1:0] tmem [16];
   logic          p1_v = 1'b0;
   logic          p2_v = 1'b0;
   logic [3:0]    p1_a = '0;
   logic [DW-1:0] p2_d = '0;

   always @(posedge clk) begin
      if (mem_wren) tmem[mem_wadd[3:0]] <= mem_idat;
      p1_v <= mem_rden;
      p1_a <= mem_radd[3:0];
      p2_v <= p1_v;
      p2_d <= tmem[p1_a];
   end

   assign mem_ovld = p2_v | force_ovld;
   assign mem_odat = force_ovld ? force_dat : p2_d;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic start_run(input int n);
      i_conf_numwords = RW'(n);
      i_start = 1'b1;
      @(negedge clk);
      i_start = 1'b0;
   endtask

   task automatic clear_phase(input int n);
      for (int k = 0; k < n; k++) begin
         check("clr_wren", 64'(mem_wren), 64'd1);
         check("clr_wadd", 64'(mem_wadd), 64'(k));
         check("clr_idat", 64'(mem_idat), 64'd0);
         @(negedge clk);
      end
      if (n == 0) begin
         check("clr0_wren", 64'(mem_wren), 64'd0);
         @(negedge clk);
      end
      check("accum_state", 64'(o_state), 64'd2);
   endtask

   task automatic acc_write(input int addr, input logic [DW-1:0] data);
      acc_wadd = AW'(addr);
      acc_idat = data;
      acc_wren = 1'b1;
      exp_w[addr] = data;
      @(negedge clk);
      acc_wren = 1'b0;
   endtask

   task automatic drain_collect(input int n, input int rdy_delay);
      int got = 0;
      int issued = 0;
      int popped = 0;
      int maxo = 0;
      int first = -1;
      int last = -1;
      bit done_seen = 1'b0;
      i_rdy = (rdy_delay == 0);
      i_accum_done = 1'b1;
      @(negedge clk);
      i_accum_done = 1'b0;
      for (int cyc = 0; cyc < 100 && !done_seen; cyc++) begin
         if (cyc == rdy_delay) i_rdy = 1'b1;
         if (o_done) begin
            done_seen = 1'b1;
         end else begin
            if (mem_rden) issued++;
            if (o_vld) begin
               check("drain_dat", 64'(o_dat), 64'(exp_w[got]));
               check("drain_last", 64'(o_last), 64'(got == n - 1));
               if (i_rdy) begin
                  if (first < 0) first = cyc;
                  last = cyc;
                  got++;
                  popped++;
               end
            end
            if (issued - popped > maxo) maxo = issued - popped;
            @(negedge clk);
         end
      end
      check("drain_words", 64'(got), 64'(n));
      check("drain_reads", 64'(issued), 64'(n));
      check("drain_done", 64'(done_seen), 64'd1);
      check("drain_credit", 64'(maxo <= FD), 64'd1);
      if (rdy_delay > 0 && n >= FD) check("drain_credit_full", 64'(maxo), 64'(FD));
      if (rdy_delay == 0 && n > 0) check("drain_rate", 64'(last - first), 64'(n - 1));
      @(negedge clk);
      check("done_pulse", 64'(o_done), 64'd0);
      check("idle_state", 64'(o_state), 64'd0);
      check("idle_busy", 64'(o_busy), 64'd0);
   endtask

   initial begin
      for (int i = 0; i < 16; i++) begin
         tmem[i]  = 32'hA5A5_0000 + 32'(i);
         exp_w[i] = '0;
      end

      // reset state
      #12;
      check("rst_state", 64'(o_state), 64'd0);
      check("rst_busy", 64'(o_busy), 64'd0);
      check("rst_wren", 64'(mem_wren), 64'd0);
      check("rst_vld", 64'(o_vld), 64'd0);
      check("rst_done", 64'(o_done), 64'd0);
      check("rst_err", 64'(o_err_conflict), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // N=4: clear, passthrough, drain at full rate
      start_run(4);
      clear_phase(4);
      acc_rden = 1'b1; acc_radd = 32'd7;
      acc_wren = 1'b1; acc_wadd = 32'd7; acc_idat = 32'h0102_0304;
      force_ovld = 1'b1; force_dat = 32'hDEAD_BEEF;
      #1;
      check("pt_rden", 64'(mem_rden), 64'd1);
      check("pt_radd", 64'(mem_radd), 64'd7);
      check("pt_wren", 64'(mem_wren), 64'd1);
      check("pt_wadd", 64'(mem_wadd), 64'd7);
      check("pt_idat", 64'(mem_idat), 64'h0102_0304);
      check("pt_ovld", 64'(acc_ovld), 64'd1);
      check("pt_odat", 64'(acc_odat), 64'hDEAD_BEEF);
      @(negedge clk);
      acc_rden = 1'b0; acc_wren = 1'b0; force_ovld = 1'b0;
      i_start = 1'b1; i_conf_numwords = 32'd9;
      @(negedge clk);
      i_start = 1'b0;
      check("start_ignored", 64'(o_state), 64'd2);
      for (int i = 0; i < 4; i++) acc_write(i, 32'(10 + i));
      repeat (3) @(negedge clk);
      drain_collect(4, 0);

      // N=8 with downstream stalled for 20 cycles
      start_run(8);
      clear_phase(8);
      for (int i = 0; i < 8; i++) acc_write(i, 32'(100 + i));
      repeat (3) @(negedge clk);
      drain_collect(8, 20);

      // N=0: no buffer traffic at all
      start_run(0);
      clear_phase(0);
      repeat (3) begin
         check("n0_wren", 64'(mem_wren), 64'd0);
         @(negedge clk);
      end
      drain_collect(0, 0);

      // reset in the middle of DRAIN with words parked in the FIFO
      start_run(4);
      clear_phase(4);
      for (int i = 0; i < 4; i++) acc_write(i, 32'(21 + i));
      repeat (3) @(negedge clk);
      i_rdy = 1'b0;
      i_accum_done = 1'b1;
      @(negedge clk);
      i_accum_done = 1'b0;
      repeat (6) @(negedge clk);
      check("mid_vld", 64'(o_vld), 64'd1);
      check("mid_dat", 64'(o_dat), 64'd21);
      #2 rst = 1'b1;
      #1;
      check("arst_vld", 64'(o_vld), 64'd0);
      check("arst_dat", 64'(o_dat), 64'd0);
      check("arst_busy", 64'(o_busy), 64'd0);
      check("arst_state", 64'(o_state), 64'd0);
      check("arst_rden", 64'(mem_rden), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      force_ovld = 1'b1; force_dat = 32'h0BAD_0BAD;
      #1;
      check("late_acc_ovld", 64'(acc_ovld), 64'd0);
      @(negedge clk);
      force_ovld = 1'b0;
      check("late_vld", 64'(o_vld), 64'd0);
      check("late_state", 64'(o_state), 64'd0);
      start_run(2);
      clear_phase(2);
      acc_write(0, 32'd55);
      acc_write(1, 32'd66);
      repeat (3) @(negedge clk);
      drain_collect(2, 0);
      check("err_clean", 64'(o_err_conflict), 64'd0);

      // accumulator touching the port outside ACCUM
      acc_wren = 1'b1; acc_wadd = 32'd3; acc_idat = 32'h1234_5678;
      #1;
      check("conf_wren", 64'(mem_wren), 64'd0);
      @(negedge clk);
      acc_wren = 1'b0;
      check("conf_err", 64'(o_err_conflict), 64'd1);
      repeat (3) @(negedge clk);
      check("conf_sticky", 64'(o_err_conflict), 64'd1);
      rst = 1'b1;
      #1;
      check("conf_rst", 64'(o_err_conflict), 64'd0);
      @(negedge clk);
      rst = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
